input_conditioner: RTL and testbench

Parametrised front end for asynchronous board inputs (push buttons, DIP switches, compass buttons): per channel it synchronises, debounces symmetrically (both press and release filtered), and produces one-cycle rise/fall pulses plus an optional auto-repeat "press" pulse. It sits between the FPGA pins and user logic such as the music streamer, replacing the separate single-purpose synchroniser, debouncer and edge-detector chain with one block of arbitrary width.

---
 rtl/input_cond_pkg.sv | 20 ++
 rtl/debounce_channel.sv | 110 +++++++++++
 rtl/input_conditioner.sv | 75 +++++++
 tb/tb_input_conditioner.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/input_cond_pkg.sv
// input_cond_pkg
// Shared defaults and helpers for the input_conditioner block.
//   - DEF_* : default parameter values used by input_conditioner and
//             debounce_channel.
//   - cnt_width(n) : bits needed to hold a counter with n states, never
//                    less than 1 (a 1-state counter still needs a wire).
package input_cond_pkg;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_SAMPLE_PERIOD = 25000;
  localparam int DEF_CNT_MAX       = 150;
  localparam int DEF_REPEAT_DELAY  = 200;
  localparam int DEF_REPEAT_RATE   = 50;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
// One channel of the input conditioner: symmetric debounce counter,
// debounced level, registered rise/fall edge pulses and the press output.
// Optional feature macro: INPUT_COND_REPEAT_EN adds an auto-repeat counter
// that re-fires press while the level is held high; without it press = rise.
// Ports:
//   clk          in  system clock
//   rst_n        in  synchronous active-low reset
//   sample_pulse in  shared debounce sample strobe (one cycle)
//   sync_bit     in  synchronised raw input for this channel
//   level        out debounced level
//   rise         out one-cycle pulse after level goes 0->1
//   fall         out one-cycle pulse after level goes 1->0
//   press        out rise plus auto-repeat pulses
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int CNT_MAX      = DEF_CNT_MAX,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_pulse,
  input  logic sync_bit,
  output logic level,
  output logic rise,
  output logic fall,
  output logic press
);

  localparam int CW = cnt_width(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic [CW-1:0] cnt;
  logic          level_d;
  logic          rise_now;

  assign rise_now = level & ~level_d;

  // Debounce: any agreeing sample throws away accumulated disagreement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      if (sample_pulse) begin
        if (sync_bit != level) begin
          if (cnt == CNT_LAST) begin
            level <= ~level;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end
      level_d <= level;
      rise    <= rise_now;
      fall    <= ~level & level_d;
    end
  end

`ifdef INPUT_COND_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = cnt_width(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_first;   // still waiting for the initial (longer) delay
  logic          rep_hit;

  assign rep_hit = sample_pulse & level &
                   (rep_first ? (rep_cnt == DELAY_LAST) : (rep_cnt == RATE_LAST));

  // Repeat counter restarts on every rise, so a repeat cannot land on a rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
      press     <= 1'b0;
    end else begin
      press <= rise_now | rep_hit;
      if (rise_now) begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end else if (!level) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end else if (rep_hit) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end else if (sample_pulse) begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end
`else
  assign press = rise;
  // Repeat parameters are meaningful only with the repeat feature.
  logic unused_rep;
  assign unused_rep = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner
// Front end for asynchronous board inputs: per channel synchronise,
// debounce (press and release), and emit rise/fall/press pulses.
// Optional feature macro: INPUT_COND_REPEAT_EN (auto-repeat on press).
// Ports:
//   clk      in  system clock, all state on rising edge
//   rst_n    in  synchronous active-low reset
//   async_in in  [WIDTH] raw asynchronous inputs, active-high
//   level    out [WIDTH] debounced level
//   rise     out [WIDTH] one-cycle pulse per 0->1 of level
//   fall     out [WIDTH] one-cycle pulse per 1->0 of level
//   press    out [WIDTH] rise plus auto-repeat pulses
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
  parameter int CNT_MAX       = DEF_CNT_MAX,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE   = DEF_REPEAT_RATE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] press
);

  localparam int TW = cnt_width(SAMPLE_PERIOD);
  localparam logic [TW-1:0] TMR_LAST = TW'(SAMPLE_PERIOD - 1);

  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [TW-1:0]    tmr;
  logic             sample_pulse;

  // Synchroniser chain; the last stage feeds the debouncers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
    end else begin
      sync_p[0] <= async_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
    end
  end

  // Shared sample timer; with SAMPLE_PERIOD=1 it stays at 0 and strobes always.
  assign sample_pulse = (tmr == TMR_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n)            tmr <= '0;
    else if (sample_pulse) tmr <= '0;
    else                   tmr <= tmr + 1'b1;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .CNT_MAX      (CNT_MAX),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_pulse (sample_pulse),
      .sync_bit     (sync_p[SYNC_STAGES-1][i]),
      .level        (level[i]),
      .rise         (rise[i]),
      .fall         (fall[i]),
      .press        (press[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner
// Directed bench for input_conditioner with WIDTH=4, SYNC_STAGES=2,
// SAMPLE_PERIOD=4, CNT_MAX=3, REPEAT_DELAY=5, REPEAT_RATE=2.
// Expectations for the auto-repeat section depend on INPUT_COND_REPEAT_EN.
// Timing notes (edge numbers counted from reset release, first edge = 1):
// sample strobes on edges 4,8,12,...; an async change made after edge k
// is seen by the debouncer from the first strobe after edge k+2.
module tb_input_conditioner;

`ifdef INPUT_COND_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] async_in;
  logic [3:0] level, rise, fall, press;

  int checks   = 0;
  int failures = 0;

  logic [3:0] acc_level, acc_rise, acc_fall, acc_press;
  int         press2_cnt;

  input_conditioner #(
    .WIDTH         (4),
    .SYNC_STAGES   (2),
    .SAMPLE_PERIOD (4),
    .CNT_MAX       (3),
    .REPEAT_DELAY  (5),
    .REPEAT_RATE   (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (async_in),
    .level    (level),
    .rise     (rise),
    .fall     (fall),
    .press    (press)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_acc();
    acc_level = '0;
    acc_rise  = '0;
    acc_fall  = '0;
    acc_press = '0;
  endtask

  // Advance n clock edges, sampling 1 time unit after each edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      acc_level  |= level;
      acc_rise   |= rise;
      acc_fall   |= fall;
      acc_press  |= press;
      press2_cnt += int'(press[2]);
    end
  endtask

  initial begin
    press2_cnt = 0;
    clear_acc();

    // Long reset with all inputs high: outputs must stay quiet.
    rst_n    = 1'b0;
    async_in = 4'hF;
    tick(100);
    check_eq("reset_quiet", {acc_level, acc_rise, acc_fall, acc_press}, 16'h0000);

    // Release: level follows on the 3rd sample (edge 12), rise on edge 13.
    rst_n = 1'b1;
    tick(11);
    check_eq("rel_level_early", level, 4'h0);
    tick(1);
    check_eq("rel_level_set", level, 4'hF);
    check_eq("rel_rise_early", rise, 4'h0);
    tick(1);
    check_eq("rel_rise", rise, 4'hF);
    check_eq("rel_press", press, 4'hF);
    tick(1);
    check_eq("rel_rise_end", {rise, press}, 8'h00);

    // Reset while level is high: no fall pulse.
    clear_acc();
    async_in = 4'h0;
    rst_n    = 1'b0;
    tick(3);
    check_eq("rst_hi_level", level, 4'h0);
    check_eq("rst_hi_nofall", acc_fall, 4'h0);

    // Channel 0 press.
    async_in = 4'b0001;
    rst_n    = 1'b1;
    tick(11);
    check_eq("ch0_level_early", level, 4'h0);
    tick(1);
    check_eq("ch0_level", level, 4'b0001);
    check_eq("ch0_rise_early", rise, 4'h0);
    tick(1);
    check_eq("ch0_rise", rise, 4'b0001);
    check_eq("ch0_press", press, 4'b0001);
    tick(1);
    check_eq("ch0_pulse_end", {rise, press}, 8'h00);
    check_eq("ch0_only_rise", acc_rise, 4'b0001);
    check_eq("ch0_nofall", acc_fall, 4'h0);

    // Two-sample glitch on channel 1, then two release glitches on held channel 0.
    clear_acc();
    async_in = 4'b0011;
    tick(8);
    async_in = 4'b0001;
    tick(12);
    check_eq("glitch1_level", level, 4'b0001);
    async_in = 4'b0000;
    tick(8);
    async_in = 4'b0001;
    tick(12);
    async_in = 4'b0000;
    tick(8);
    async_in = 4'b0001;
    tick(12);
    check_eq("glitch0_level", level, 4'b0001);
    check_eq("glitch_norise", acc_rise, 4'h0);
    check_eq("glitch_nofall", acc_fall, 4'h0);

    // Channel 0 release: level drops on edge 88, fall on edge 89.
    clear_acc();
    async_in = 4'b0000;
    tick(13);
    check_eq("ch0_rel_early", level, 4'b0001);
    tick(1);
    check_eq("ch0_rel_level", level, 4'h0);
    check_eq("ch0_fall_early", fall, 4'h0);
    tick(1);
    check_eq("ch0_fall", fall, 4'b0001);
    check_eq("ch0_fall_norise", rise, 4'h0);
    tick(1);
    check_eq("ch0_fall_end", fall, 4'h0);
    check_eq("ch0_rel_acc", {acc_rise, acc_fall}, 8'h01);

    // Channel 2 held: rise on 105, repeats on 124, then every 8 cycles.
    clear_acc();
    press2_cnt = 0;
    async_in   = 4'b0100;
    tick(14);
    check_eq("ch2_level", level, 4'b0100);
    tick(1);
    check_eq("ch2_rise", rise, 4'b0100);
    check_eq("ch2_press", press, 4'b0100);
    tick(18);
    check_eq("ch2_before_rep", press, 4'h0);
    tick(1);
    check_eq("ch2_rep1", press, REP ? 4'b0100 : 4'b0000);
    tick(7);
    check_eq("ch2_between_rep", press, 4'h0);
    tick(1);
    check_eq("ch2_rep2", press, REP ? 4'b0100 : 4'b0000);
    tick(52);
    check_eq("ch2_press_count", press2_cnt, REP ? 9 : 1);
    check_eq("ch2_press_chans", acc_press, 4'b0100);
    check_eq("ch2_single_rise", acc_rise, 4'b0100);

    // Channel 3 mid-count reset: progress must be discarded.
    clear_acc();
    async_in = 4'b1000;
    tick(8);
    rst_n = 1'b0;
    tick(1);
    check_eq("mid_rst_level", level, 4'h0);
    rst_n = 1'b1;
    tick(11);
    check_eq("ch3_level_early", level, 4'h0);
    tick(1);
    check_eq("ch3_level", level, 4'b1000);
    tick(1);
    check_eq("ch3_rise", rise, 4'b1000);
    check_eq("ch3_press", press, 4'b1000);
    tick(1);
    check_eq("ch3_pulse_end", rise, 4'h0);
    check_eq("ch3_acc_rise", acc_rise, 4'b1000);
    check_eq("ch3_nofall", acc_fall, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
